siso_layer_scheduler: RTL and testbench
=======================================

// Module: siso_layer_scheduler
// PURPOSE
// Layered-decoding controller that drives the read side of the SISO row unit. Issues
//   per-layer LLR/E read-address bursts and tracks write-backs returned by the row unit.
// Stalls each layer until every write-back of the previous layer has landed (layer
//   dependency through L memory). Counts iterations and ends on max_iter or early_term.
// PARAMETERS
// LAYERS      2   number of layers per iteration
// ADDRDEPTH   20  addresses per layer (ceil(Z/P))
// ADDRWIDTH   5   address bus width; 2**ADDRWIDTH >= ADDRDEPTH
// ITERBITS    4   width of iteration count / max_iter
// LAYERBITS   1   width of layer index (>= clog2(LAYERS), min 1)
// PORTS
// clk          in   1          clock, rising edge
// rst          in   1          asynchronous active-low reset
// start        in   1          1-cycle request to start a decode; ignored when busy=1
// max_iter     in   ITERBITS   iteration limit, sampled on accepted start; 0 treated as 1
// early_term   in   1          syndrome check passed; sampled only in ITER_END
// abort        in   1          stop issuing, drain pipeline, finish with aborted=1
// wren_in      in   1          row-unit write-back strobe (one per issued address)
// rdlayer      out  LAYERBITS  layer index of current read
// rdaddress    out  ADDRWIDTH  address of current read
// rden_LLR     out  1          L-memory read enable / row-unit issue strobe
// rden_E       out  1          E-memory read enable; always equals rden_LLR
// first_iter   out  1          high throughout iteration 0 (downstream zeroes E)
// busy         out  1          high from accepted start until done cycle inclusive
// done         out  1          1-cycle pulse at decode end
// aborted      out  1          valid with done; 1 if ended by abort
// iter_count   out  ITERBITS   iterations completed; held after done until next start
// err          out  1          sticky: wren_in seen with inflight==0; cleared by start
// BEHAVIOUR
// - All outputs registered. Reset: every output 0; state IDLE; inflight 0.
// - States: IDLE, ISSUE, DRAIN, ITER_END, FLUSH, DONE.
// - IDLE: start=1 -> ISSUE; layer=0, addr=0, iter_count=0, first_iter=1, busy=1,
//   max_iter latched.
// - ISSUE: rden_LLR=rden_E=1, rdlayer=layer, rdaddress=addr. One address per cycle, no
//   gaps. Start accepted at edge k -> first rden visible after edge k+1 with addr 0.
//   addr runs 0..ADDRDEPTH-1, then ISSUE->DRAIN, rden deasserted the next cycle.
// - DRAIN: wait until inflight==0 (count includes this cycle's wren_in).
//   Not last layer -> layer+1, addr=0, ISSUE.
//   Last layer -> ITER_END.
// - ITER_END (1 cycle): iter_count+1. If new count==max_iter or early_term=1 -> DONE;
//   else layer=0, first_iter=0, ISSUE.
// - DONE (1 cycle): done=1 (aborted as set), busy drops the next cycle, -> IDLE.
// - abort=1 in ISSUE/DRAIN/ITER_END: rden drops the next cycle -> FLUSH. FLUSH waits
//   inflight==0 -> DONE with aborted=1; iter_count is not incremented.
//   abort in IDLE/DONE: ignored.
// - inflight counter, ADDRWIDTH+1 bits: +1 on issued rden_LLR, -1 on wren_in, net 0 if
//   both in the same cycle. wren_in with inflight==0 -> err=1, counter saturates at 0.
// - start while busy: ignored, no side effects. Simultaneous start and abort in IDLE:
//   start wins.
// - Async reset mid-burst: outputs to 0 immediately. Write-backs still in the row-unit
//   pipeline are not tracked; the controlling logic must reset the row unit with it.
// - Minimum layer turnaround = row-unit pipeline latency (about 11 cycles) + 1 DRAIN exit
//   cycle.
// STRUCTURE
// - Shared header siso_sched_defs.vh: state encodings (localparam), default
//   LAYERS/ADDRDEPTH/ADDRWIDTH, shared with row-unit instantiation.
// - Sub-module siso_inflight_ctr: up/down counter with zero flag, underflow err,
//   async active-low reset.
// - Top level: FSM + address/layer/iteration counters.
// TESTING
// - Row-unit model with 12-cycle wren_in echo. start, max_iter=2: rden bursts addr
//   0..19 layer0, 0..19 layer1, repeated twice; each layer starts only after 20
//   wren_in. done pulse, iter_count=2, aborted=0.
// - max_iter=0: behaves as 1 iteration, done with iter_count=1. Check first_iter=1
//   throughout.
// - early_term=1 held from cycle 0, max_iter=8: ends after iteration 1, iter_count=1.
// - abort mid layer 0 at addr 7: 8 issued, rden low next cycle; done only after 8th
//   wren_in, aborted=1, iter_count=0.
// - Inject extra wren_in with inflight=0: err=1, stays 1; next start clears it. Also
//   start pulses while busy are ignored.
// - Async reset (rst=0) mid-ISSUE, asserted off-edge: all outputs 0 before the next
//   clk edge. After release, IDLE until start.

Source files
------------

// File: rtl/siso_layer_scheduler_pkg.sv
// Shared definitions for the SISO layered-decoding read scheduler.
package siso_layer_scheduler_pkg;

    // Default geometry, shared with the row-unit instantiation.
    localparam int unsigned DefLayers    = 2;
    localparam int unsigned DefAddrDepth = 20;
    localparam int unsigned DefAddrWidth = 5;
    localparam int unsigned DefIterBits  = 4;
    localparam int unsigned DefLayerBits = 1;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StIssue   = 3'd1,
        StDrain   = 3'd2,
        StIterEnd = 3'd3,
        StFlush   = 3'd4,
        StDone    = 3'd5
    } sched_state_e;

    // An iteration limit of zero still runs one iteration.
    function automatic int unsigned eff_max_iter(input int unsigned m);
        return (m == 0) ? 1 : m;
    endfunction

endpackage

// File: rtl/siso_layer_scheduler_inflight_ctr.sv
// Up/down counter of row-unit reads still awaiting write-back.
module siso_layer_scheduler_inflight_ctr #(
    parameter int unsigned WIDTH = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr_err,
    output logic zero_next,
    output logic err
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             err_q;
    logic             err_d;
    logic             underflow;

    // Next count; a write-back with nothing in flight is flagged and ignored.
    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        if (inc && !dec) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else if (dec && !inc) begin
            if (cnt_q == '0) begin
                underflow = 1'b1;
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
        err_d = clr_err ? 1'b0 : (err_q | underflow);
    end

    // Zero flag looks at the count after this cycle's strobes.
    assign zero_next = (cnt_d == '0);
    assign err       = err_q;

    // Counter and sticky error state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/siso_layer_scheduler.sv
// Layered-decoding read scheduler: issues per-layer address bursts, waits for
// write-backs between layers, counts iterations, supports abort.
module siso_layer_scheduler
    import siso_layer_scheduler_pkg::*;
#(
    parameter int unsigned LAYERS    = DefLayers,
    parameter int unsigned ADDRDEPTH = DefAddrDepth,
    parameter int unsigned ADDRWIDTH = DefAddrWidth,
    parameter int unsigned ITERBITS  = DefIterBits,
    parameter int unsigned LAYERBITS = DefLayerBits
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ITERBITS-1:0]  max_iter,
    input  logic                 early_term,
    input  logic                 abort,
    input  logic                 wren_in,
    output logic [LAYERBITS-1:0] rdlayer,
    output logic [ADDRWIDTH-1:0] rdaddress,
    output logic                 rden_LLR,
    output logic                 rden_E,
    output logic                 first_iter,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [ITERBITS-1:0]  iter_count,
    output logic                 err
);

    sched_state_e         state_q, state_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [LAYERBITS-1:0] layer_q, layer_d;
    logic [ITERBITS-1:0]  iter_q, iter_d;
    logic [ITERBITS-1:0]  max_q, max_d;
    logic [ITERBITS-1:0]  iter_inc;
    logic                 first_q, first_d;
    logic                 aborted_q, aborted_d;
    logic                 issue;
    logic                 clr_err;
    logic                 zero_next;

    logic                 rden_q;
    logic [ADDRWIDTH-1:0] rdaddress_q;
    logic [LAYERBITS-1:0] rdlayer_q;
    logic                 busy_q;
    logic                 done_q;

    assign iter_inc = iter_q + ITERBITS'(1);

    // Next-state and counter updates.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        layer_d   = layer_q;
        iter_d    = iter_q;
        max_d     = max_q;
        first_d   = first_q;
        aborted_d = aborted_q;
        issue     = 1'b0;
        clr_err   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // abort is ignored here, so start wins when both are high.
                if (start) begin
                    state_d   = StIssue;
                    addr_d    = '0;
                    layer_d   = '0;
                    iter_d    = '0;
                    max_d     = ITERBITS'(eff_max_iter(int'(max_iter)));
                    first_d   = 1'b1;
                    aborted_d = 1'b0;
                    clr_err   = 1'b1;
                end
            end
            StIssue: begin
                if (abort) begin
                    state_d = StFlush;
                end else begin
                    issue = 1'b1;
                    if (addr_q == ADDRWIDTH'(ADDRDEPTH - 1)) begin
                        state_d = StDrain;
                    end else begin
                        addr_d = addr_q + ADDRWIDTH'(1);
                    end
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d = StFlush;
                end else if (zero_next) begin
                    if (layer_q == LAYERBITS'(LAYERS - 1)) begin
                        state_d = StIterEnd;
                    end else begin
                        layer_d = layer_q + LAYERBITS'(1);
                        addr_d  = '0;
                        state_d = StIssue;
                    end
                end
            end
            StIterEnd: begin
                if (abort) begin
                    state_d = StFlush;
                end else begin
                    iter_d = iter_inc;
                    if ((iter_inc == max_q) || early_term) begin
                        state_d = StDone;
                    end else begin
                        layer_d = '0;
                        addr_d  = '0;
                        first_d = 1'b0;
                        state_d = StIssue;
                    end
                end
            end
            StFlush: begin
                if (zero_next) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                first_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and control counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            layer_q   <= '0;
            iter_q    <= '0;
            max_q     <= '0;
            first_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            layer_q   <= layer_d;
            iter_q    <= iter_d;
            max_q     <= max_d;
            first_q   <= first_d;
            aborted_q <= aborted_d;
        end
    end

    // Registered read-side and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rden_q      <= 1'b0;
            rdaddress_q <= '0;
            rdlayer_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rden_q <= issue;
            if (issue) begin
                rdaddress_q <= addr_q;
                rdlayer_q   <= layer_q;
            end
            busy_q <= (state_d != StIdle);
            done_q <= (state_d == StDone);
        end
    end

    siso_layer_scheduler_inflight_ctr #(
        .WIDTH(ADDRWIDTH + 1)
    ) u_inflight (
        .clk      (clk),
        .rst      (rst),
        .inc      (rden_q),
        .dec      (wren_in),
        .clr_err  (clr_err),
        .zero_next(zero_next),
        .err      (err)
    );

    assign rden_LLR   = rden_q;
    assign rden_E     = rden_q;
    assign rdaddress  = rdaddress_q;
    assign rdlayer    = rdlayer_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign first_iter = first_q;
    assign aborted    = aborted_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_siso_layer_scheduler.sv
// Bench for siso_layer_scheduler: 12-cycle row-unit echo, expected read
// sequence built from the iteration/layer/address rules.
module tb_siso_layer_scheduler;

    localparam int LAYERS = 2;
    localparam int DEPTH  = 20;
    localparam int PER_IT = LAYERS * DEPTH;

    typedef struct packed {
        logic [0:0] layer;
        logic [4:0] addr;
        logic       first;
    } issue_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] max_iter;
    logic       early_term;
    logic       abort;
    logic       wren_in;
    logic [0:0] rdlayer;
    logic [4:0] rdaddress;
    logic       rden_LLR;
    logic       rden_E;
    logic       first_iter;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] iter_count;
    logic       err;

    logic [11:0] pipe;
    logic        echo_out;
    logic        inj;

    int n_vec;
    int n_err;

    siso_layer_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .max_iter  (max_iter),
        .early_term(early_term),
        .abort     (abort),
        .wren_in   (wren_in),
        .rdlayer   (rdlayer),
        .rdaddress (rdaddress),
        .rden_LLR  (rden_LLR),
        .rden_E    (rden_E),
        .first_iter(first_iter),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .iter_count(iter_count),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Row-unit model: every issued read returns a write-back 12 cycles later.
    always @(posedge clk or negedge rst) begin
        if (!rst) pipe <= '0;
        else      pipe <= {pipe[10:0], rden_LLR};
    end
    assign echo_out = pipe[11];
    assign wren_in  = echo_out | inj;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_decode(input int mi, input bit et, input int abort_k, input bit st_abort);
        issue_t exp_q[$];
        issue_t e;
        int     n_it;
        int     exp_iter;
        int     issued;
        int     landed;
        bit     fin;
        bit     abort_chk;
        n_it = (mi == 0) ? 1 : mi;
        if (et) n_it = 1;
        for (int it = 0; it < n_it; it++)
            for (int l = 0; l < LAYERS; l++)
                for (int a = 0; a < DEPTH; a++)
                    exp_q.push_back('{layer: 1'(l), addr: 5'(a), first: (it == 0)});
        if (abort_k > 0) begin
            while (exp_q.size() > abort_k) exp_q.delete(exp_q.size() - 1);
            exp_iter = (abort_k - 1) / PER_IT;
        end else begin
            exp_iter = n_it;
        end

        @(negedge clk);
        start      = 1'b1;
        max_iter   = 4'(mi);
        early_term = et;
        abort      = st_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_no_rden_yet", rden_LLR, 0);
        chk("start_err_clear", err, 0);
        chk("start_iter_zero", iter_count, 0);
        chk("start_first_iter", first_iter, 1);
        chk("start_no_done", done, 0);

        issued    = 0;
        landed    = 0;
        fin       = 1'b0;
        abort_chk = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            abort = 1'b0;
            if (cyc == 0) chk("first_rden_latency", rden_LLR, 1);
            chk("rden_E_eq_LLR", rden_E, rden_LLR);
            if (abort_chk) begin
                chk("abort_rden_drop", rden_LLR, 0);
                abort_chk = 1'b0;
            end
            if (rden_LLR) begin
                if (exp_q.size() == 0) begin
                    chk("extra_issue", rden_LLR, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdlayer", rdlayer, e.layer);
                    chk("rdaddress", rdaddress, e.addr);
                    chk("first_iter", first_iter, e.first);
                    if (e.addr == 0 && issued > 0) chk("layer_dependency", landed, issued);
                end
                issued++;
                if (issued == abort_k) begin
                    abort     = 1'b1;
                    abort_chk = 1'b1;
                end
            end
            landed += int'(echo_out);
            if (done) begin
                start = 1'b0;
                fin   = 1'b1;
                chk("done_iter_count", iter_count, exp_iter);
                chk("done_aborted", aborted, (abort_k > 0));
                chk("done_missing_issues", exp_q.size(), 0);
                chk("done_after_writebacks", landed, issued);
                chk("done_busy", busy, 1);
                chk("done_err", err, 0);
            end else begin
                // Stray start pulses while busy must have no effect.
                start    = ($urandom_range(0, 15) == 0);
                max_iter = 4'($urandom);
            end
        end
        chk("done_timeout", fin, 1);
        start = 1'b0;
        @(negedge clk);
        chk("post_done_busy", busy, 0);
        chk("post_done_pulse", done, 0);
        chk("post_done_iter_held", iter_count, exp_iter);
        early_term = 1'b0;
    endtask

    initial begin
        bit found;
        int mi;
        int n_it;
        int ak;
        bit et;
        n_vec      = 0;
        n_err      = 0;
        clk        = 1'b0;
        rst        = 1'b0;
        start      = 1'b0;
        max_iter   = '0;
        early_term = 1'b0;
        abort      = 1'b0;
        inj        = 1'b0;
        #1;
        chk("reset_outputs", {rdlayer, rdaddress, rden_LLR, rden_E, first_iter, busy, done,
            aborted, iter_count, err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // abort alone in IDLE does nothing.
        abort = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_abort_busy", busy, 0);
            chk("idle_abort_rden", rden_LLR, 0);
        end
        abort = 1'b0;

        run_decode(2, 1'b0, 0, 1'b0);
        run_decode(0, 1'b0, 0, 1'b0);
        run_decode(8, 1'b1, 0, 1'b0);
        run_decode(2, 1'b0, 8, 1'b0);

        // Stray write-back with nothing in flight sets a sticky error.
        @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        chk("err_set", err, 1);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);
        run_decode(1, 1'b0, 0, 1'b1);

        // Asynchronous reset in the middle of a burst.
        @(negedge clk);
        start    = 1'b1;
        max_iter = 4'd1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (rden_LLR && rdaddress == 5'd5) found = 1'b1;
        end
        chk("reach_addr5", found, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_outputs", {rdlayer, rdaddress, rden_LLR, rden_E, first_iter, busy,
            done, aborted, iter_count, err}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("post_reset_idle_busy", busy, 0);
            chk("post_reset_idle_rden", rden_LLR, 0);
        end
        run_decode(1, 1'b0, 0, 1'b0);

        // Randomised decodes.
        for (int r = 0; r < 5; r++) begin
            mi   = $urandom_range(1, 3);
            et   = 1'($urandom_range(0, 1));
            n_it = et ? 1 : mi;
            ak   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, n_it * PER_IT)) : 0;
            run_decode(mi, et, ak, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
